seq_scan_ctrl: RTL and testbench

Frame-level controller that serialises parallel data words MSB-first into a bit-serial pattern detector and counts pattern occurrences per frame.
- Accepts words over a valid/ready handshake.
- Runs the detector one bit per clock; detection history carries across word boundaries within a frame and is cleared at each new frame.
- Reports a per-match pulse, a saturating match count and a one-cycle frame-done strobe.
- Sits between a byte-stream source and the status/interrupt logic of the FSM detector subsystem.

---
 rtl/seq_pkg.sv | 13 +
 rtl/seq_match_window.sv | 46 ++++
 rtl/seq_scan_ctrl.sv | 122 ++++++++++++
 tb/tb_seq_scan_ctrl.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_pkg.sv
// Shared types and default pattern constants for the sequence scan controller.
package seq_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    localparam int                       DEF_PAT_LEN = 4;
    localparam logic [DEF_PAT_LEN-1:0]   DEF_PATTERN = 4'b1100;

endpackage

// File: rtl/seq_match_window.sv
// Bit-serial pattern window: keeps the last PAT_LEN bits plus a saturating
// count of bits seen, and flags a match on the bit being shifted in now.
module seq_match_window
    import seq_pkg::*;
#(
    parameter int                 PAT_LEN = DEF_PAT_LEN,
    parameter logic [PAT_LEN-1:0] PATTERN = DEF_PATTERN
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic bit_en,
    input  logic bit_in,
    output logic match
);

    localparam int SEEN_W = $clog2(PAT_LEN + 1);

    logic [PAT_LEN-1:0] win;
    logic [SEEN_W-1:0]  seen;
    logic [PAT_LEN:0]   win_ext;
    logic [PAT_LEN-1:0] win_nxt;
    logic               full_nxt;

    // The oldest bit falls off the top; the match looks at the window as it will be.
    assign win_ext  = {win, bit_in};
    assign win_nxt  = win_ext[PAT_LEN-1:0];
    assign full_nxt = (int'(seen) + 1) >= PAT_LEN;
    assign match    = bit_en && full_nxt && (win_nxt == PATTERN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            win  <= '0;
            seen <= '0;
        end else if (clr) begin
            win  <= '0;
            seen <= '0;
        end else if (bit_en) begin
            win <= win_nxt;
            if (seen != SEEN_W'(PAT_LEN))
                seen <= seen + SEEN_W'(1);
        end
    end

endmodule

// File: rtl/seq_scan_ctrl.sv
// Frame controller: accepts words over valid/ready, serialises them MSB-first
// into the match window and counts matches per frame.
module seq_scan_ctrl
    import seq_pkg::*;
#(
    parameter int                 DATA_W  = 8,
    parameter int                 PAT_LEN = DEF_PAT_LEN,
    parameter logic [PAT_LEN-1:0] PATTERN = DEF_PATTERN,
    parameter int                 CNT_W   = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    output logic              in_ready,
    output logic              det_pulse,
    output logic [CNT_W-1:0]  match_count,
    output logic              done,
    output logic              busy
);

    localparam int               BC_W    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [BC_W-1:0]  BC_LOAD = BC_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t            state, state_nxt;
    logic [DATA_W-1:0] sreg;
    logic [BC_W-1:0]   bit_cnt;
    logic              last_q;
    logic              new_frame;
    logic              shift_en;
    logic              accept;
    logic              clr_win;
    logic              match;

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_nxt = state;
        in_ready  = 1'b0;
        shift_en  = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid)
                    state_nxt = SHIFT;
            end
            SHIFT: begin
                shift_en = 1'b1;
                if (bit_cnt == '0) begin
                    if (last_q) begin
                        state_nxt = DONE;
                    end else begin
                        // Reloading on the final bit keeps a sustained rate of DATA_W cycles per word.
                        in_ready  = 1'b1;
                        state_nxt = in_valid ? SHIFT : IDLE;
                    end
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign accept  = in_valid && in_ready;
    assign clr_win = accept && new_frame;
    assign done    = (state == DONE);
    assign busy    = (state != IDLE);

    seq_match_window #(
        .PAT_LEN (PAT_LEN),
        .PATTERN (PATTERN)
    ) u_window (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (clr_win),
        .bit_en (shift_en),
        .bit_in (sreg[DATA_W-1]),
        .match  (match)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sreg        <= '0;
            bit_cnt     <= '0;
            last_q      <= 1'b0;
            new_frame   <= 1'b1;
            det_pulse   <= 1'b0;
            match_count <= '0;
        end else begin
            if (accept) begin
                sreg    <= in_data;
                bit_cnt <= BC_LOAD;
                last_q  <= in_last;
            end else if (shift_en) begin
                sreg    <= sreg << 1;
                bit_cnt <= bit_cnt - BC_W'(1);
            end

            if (done)
                new_frame <= 1'b1;
            else if (accept)
                new_frame <= 1'b0;

            det_pulse <= shift_en && match;

            // The count of a finished frame stays visible until the next frame's first word.
            if (clr_win)
                match_count <= '0;
            else if (shift_en && match && (match_count != CNT_MAX))
                match_count <= match_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_seq_scan_ctrl.sv
// Self-checking bench for seq_scan_ctrl: directed frames with literal
// expectations plus randomized frames checked every cycle against a bit-history model.
module tb_seq_scan_ctrl;

    localparam int         DATA_W  = 8;
    localparam int         PAT_LEN = 4;
    localparam logic [3:0] PAT     = 4'b1100;

    logic       clk      = 1'b0;
    logic       rst_n    = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_data  = 8'h00;
    logic       in_last  = 1'b0;

    logic       in_ready, det_pulse, done, busy;
    logic [7:0] match_count;
    logic       ready_s, det_s, done_s, busy_s;
    logic [1:0] count_s;

    seq_scan_ctrl u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_last     (in_last),
        .in_ready    (in_ready),
        .det_pulse   (det_pulse),
        .match_count (match_count),
        .done        (done),
        .busy        (busy)
    );

    seq_scan_ctrl #(.CNT_W(2)) u_sat (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_last     (in_last),
        .in_ready    (ready_s),
        .det_pulse   (det_s),
        .match_count (count_s),
        .done        (done_s),
        .busy        (busy_s)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    int acc_cyc = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) cyc++;

    // Reference model: remembers the serial bits of the current frame and
    // looks for PAT in the most recent PAT_LEN of them.
    int         m_left;
    logic [7:0] m_word;
    bit         m_last, m_new, m_acc;
    bit         m_hist[$];
    int         m_v;
    bit         exp_ready, exp_det, exp_done, exp_busy;
    int         exp_cnt, exp_cnt_s;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_left = 0; m_new = 1'b1; m_last = 1'b0; m_hist.delete();
            exp_ready = 1'b1; exp_det = 1'b0; exp_done = 1'b0; exp_busy = 1'b0;
            exp_cnt = 0; exp_cnt_s = 0;
        end else begin
            m_acc    = in_valid && exp_ready;
            exp_det  = 1'b0;
            exp_done = 1'b0;
            if (m_left > 0) begin
                m_hist.push_back(m_word[m_left-1]);
                m_left--;
                if (m_hist.size() > PAT_LEN) void'(m_hist.pop_front());
                if (m_hist.size() == PAT_LEN) begin
                    m_v = 0;
                    foreach (m_hist[i]) m_v = (m_v << 1) | int'(m_hist[i]);
                    if (m_v == int'(PAT)) begin
                        exp_det = 1'b1;
                        if (exp_cnt < 255) exp_cnt++;
                        if (exp_cnt_s < 3) exp_cnt_s++;
                    end
                end
                if (m_left == 0 && m_last) begin
                    exp_done = 1'b1;
                    m_new    = 1'b1;
                end
            end
            if (m_acc) begin
                if (m_new) begin
                    m_hist.delete();
                    exp_cnt = 0; exp_cnt_s = 0; m_new = 1'b0;
                end
                m_word = in_data; m_last = in_last; m_left = DATA_W;
            end
            exp_ready = !exp_done && (m_left == 0 || (m_left == 1 && !m_last));
            exp_busy  = (m_left > 0) || exp_done;
        end
    end

    always @(negedge clk) begin
        if (rst_n && chk_en) begin
            check("in_ready",    in_ready,    exp_ready);
            check("det_pulse",   det_pulse,   exp_det);
            check("done",        done,        exp_done);
            check("busy",        busy,        exp_busy);
            check("match_count", match_count, exp_cnt);
            check("sat_ready",   ready_s,     exp_ready);
            check("sat_det",     det_s,       exp_det);
            check("sat_done",    done_s,      exp_done);
            check("sat_busy",    busy_s,      exp_busy);
            check("sat_count",   count_s,     exp_cnt_s);
        end
    end

    // Event log used by the directed tests' literal expectations.
    int pulse_q[$];
    int satc_q[$];
    int done_q[$];
    int done_cnt, done_cnt_s;

    always @(negedge clk) begin
        if (rst_n) begin
            if (det_pulse) begin
                pulse_q.push_back(cyc);
                satc_q.push_back(int'(count_s));
            end
            if (done) begin
                done_q.push_back(cyc);
                done_cnt   = int'(match_count);
                done_cnt_s = int'(count_s);
            end
        end
    end

    task automatic clr_log();
        pulse_q.delete(); satc_q.delete(); done_q.delete();
        done_cnt = -1; done_cnt_s = -1;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] d, input logic l);
        bit ok;
        ok = 1'b0;
        in_valid = 1'b1; in_data = d; in_last = l;
        for (int n = 0; n < 64 && !ok; n++) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
        end
        check("send_accept", ok, 1);
        acc_cyc  = cyc;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    int a1, a2;
    logic [7:0] pick[4] = '{8'hCC, 8'h66, 8'h33, 8'h99};

    initial begin
        clr_log();
        idle(3);
        check("rst_ready", in_ready, 1);
        check("rst_count", match_count, 0);
        check("rst_busy",  busy, 0);
        check("rst_done",  done, 0);
        rst_n  = 1'b1;
        chk_en = 1'b1;
        idle(2);

        // Single-word frame 11001100: two matches, the second on the final bit.
        clr_log();
        send(8'hCC, 1'b1); a1 = acc_cyc;
        idle(12);
        check("t1_npulse", pulse_q.size(), 2);
        if (pulse_q.size() == 2) begin
            check("t1_pulse0", pulse_q[0] - a1, 4);
            check("t1_pulse1", pulse_q[1] - a1, 8);
        end
        check("t1_ndone", done_q.size(), 1);
        if (done_q.size() == 1) check("t1_done_at", done_q[0] - a1, 8);
        check("t1_count", done_cnt, 2);

        // Match spanning a word boundary with back-to-back words.
        clr_log();
        send(8'h03, 1'b0); a1 = acc_cyc;
        send(8'h00, 1'b1); a2 = acc_cyc;
        idle(12);
        check("t2_b2b", a2 - a1, 8);
        check("t2_npulse", pulse_q.size(), 1);
        if (pulse_q.size() == 1) check("t2_pulse0", pulse_q[0] - a2, 2);
        check("t2_ndone", done_q.size(), 1);
        if (done_q.size() == 1) check("t2_done_at", done_q[0] - a1, 16);
        check("t2_count", done_cnt, 1);

        // History must not carry from one frame into the next.
        clr_log();
        send(8'h06, 1'b1);
        idle(12);
        check("t3a_count", done_cnt, 0);
        clr_log();
        send(8'h7F, 1'b1);
        idle(12);
        check("t3b_npulse", pulse_q.size(), 0);
        check("t3b_count", done_cnt, 0);
        check("t3b_ndone", done_q.size(), 1);

        // Two-bit counter saturates at 3 while pulses continue.
        clr_log();
        send(8'hCC, 1'b0);
        send(8'hCC, 1'b1);
        idle(20);
        check("t4_npulse", pulse_q.size(), 4);
        if (satc_q.size() == 4) begin
            check("t4_sat0", satc_q[0], 1);
            check("t4_sat1", satc_q[1], 2);
            check("t4_sat2", satc_q[2], 3);
            check("t4_sat3", satc_q[3], 3);
        end
        check("t4_done_sat", done_cnt_s, 3);
        check("t4_done_cnt", done_cnt, 4);

        // Reset in the middle of a frame.
        clr_log();
        send(8'hCC, 1'b1);
        idle(5);
        rst_n = 1'b0;
        #1;
        check("t5_ready", in_ready, 1);
        check("t5_count", match_count, 0);
        check("t5_done",  done, 0);
        check("t5_busy",  busy, 0);
        idle(3);
        rst_n = 1'b1;
        check("t5_no_done", done_q.size(), 0);
        clr_log();
        send(8'hCC, 1'b1);
        idle(12);
        check("t5_count_after", done_cnt, 2);
        check("t5_ndone", done_q.size(), 1);

        // Source stalls between words; the window survives the gap.
        clr_log();
        send(8'h03, 1'b0);
        idle(11);
        check("t6_idle_ready", in_ready, 1);
        check("t6_idle_busy", busy, 0);
        send(8'h00, 1'b1);
        idle(12);
        check("t6_npulse", pulse_q.size(), 1);
        check("t6_count", done_cnt, 1);

        // Randomized frames, checked every cycle by the model.
        for (int f = 0; f < 40; f++) begin
            int nw;
            nw = $urandom_range(1, 4);
            for (int w = 0; w < nw; w++) begin
                logic [7:0] d;
                d = ($urandom_range(0, 1) == 0) ? 8'($urandom) : pick[$urandom_range(0, 3)];
                send(d, w == nw - 1);
                if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 10));
            end
            idle($urandom_range(0, 12));
        end
        idle(20);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
